bit128to16: RTL and testbench

Read-side counterpart of the ECM 16-to-128-bit packer. On a request it fetches one ECM packet from DDR3 as a sequence of 128-bit words, buffers them, and re-serialises them MSB-first into the 16-bit ECM packet stream with sof/eof framing and backpressure. It sits between the DDR3 read-port arbiter and the ECM insertion logic.

---
 rtl/bit128to16.sv | 255 +++++++++++++++++++++++++
 tb/tb_bit128to16.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bit128to16.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : bit128to16
// Purpose  : Fetches one ECM packet from DDR3 as 128-bit words, buffers them
//            in a credit-controlled FIFO and re-serialises them MSB lane
//            first into the 16-bit ECM packet stream with sof/eof framing.
// Options  : BIT128TO16_CHK_EN - enables the sticky rd_err protocol flag.
// Revision : 1.0 - initial release
// ============================================================================
module bit128to16 #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         rd_req,
    input  logic [9:0]   rd_index,
    input  logic [7:0]   rd_word_num,
    output logic         rd_ack,
    output logic         rd_busy,
    output logic         ddr_rd_cmd_val,
    output logic [15:0]  ddr_rd_cmd_addr,
    input  logic         ddr_rd_cmd_rdy,
    input  logic [127:0] ddr_rd_data,
    input  logic         ddr_rd_data_val,
    output logic [9:0]   ecm_pkt_index,
    output logic         ecm_pkt_sof,
    output logic         ecm_pkt_eof,
    output logic [15:0]  ecm_pkt_data,
    output logic         ecm_pkt_val,
    input  logic         ecm_pkt_rdy,
    output logic         rd_err
);

    localparam int c_AW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int c_CNTW = c_AW + 1;
    localparam logic [c_CNTW:0] c_DEPTH = (c_CNTW + 1)'(FIFO_DEPTH);
    localparam logic [7:0]      c_MAX_WORDS = 8'd248;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CMD   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t              r_state;
    logic                r_rd_ack;
    logic                r_rd_busy;
    logic [9:0]          r_index;
    logic [7:0]          r_word_num;
    logic [5:0]          r_nwords;
    logic [5:0]          r_cmd_cnt;
    logic                r_cmd_val;
    logic [c_CNTW-1:0]   r_outstanding;
    logic [c_CNTW-1:0]   r_count;
    logic [c_AW-1:0]     r_wr_ptr;
    logic [c_AW-1:0]     r_rd_ptr;
    logic [127:0]        r_mem [FIFO_DEPTH];
    logic [127:0]        r_word;
    logic [2:0]          r_lane;
    logic                r_have;
    logic [7:0]          r_out_cnt;
    logic                r_pkt_val;
    logic                r_pkt_sof;
    logic                r_pkt_eof;
    logic [15:0]         r_pkt_data;

    logic                w_accept;
    logic                w_legal;
    logic [5:0]          w_nwords;
    logic                w_cmd_fire;
    logic                w_push;
    logic                w_pop;
    logic                w_adv;
    logic                w_last;
    logic                w_eof_hs;
    logic [127:0]        w_head;
    logic [c_CNTW-1:0]   w_count_nxt;
    logic [c_CNTW-1:0]   w_out_nxt;
    logic [c_CNTW:0]     w_credit_sum;
    logic                w_credit_ok;

    assign w_accept   = (r_state == S_IDLE) && rd_req && !r_rd_ack;
    assign w_legal    = (rd_word_num != 8'd0) && (rd_word_num <= c_MAX_WORDS);
    // Number of 128-bit words needed: ceil(rd_word_num / 8)
    assign w_nwords   = {1'b0, rd_word_num[7:3]} + {5'd0, |rd_word_num[2:0]};
    assign w_cmd_fire = r_cmd_val && ddr_rd_cmd_rdy;
    // Data with no outstanding command is unsolicited and never enters the FIFO
    assign w_push     = ddr_rd_data_val && (r_outstanding != '0);
    assign w_adv      = !r_pkt_val || ecm_pkt_rdy;
    assign w_last     = ((r_out_cnt + 8'd1) == r_word_num);
    assign w_pop      = w_adv && !r_have && (r_count != '0) &&
                        (r_state != S_IDLE) && (r_out_cnt != r_word_num);
    assign w_eof_hs   = r_pkt_val && r_pkt_eof && ecm_pkt_rdy;
    assign w_head     = r_mem[r_rd_ptr];

    // Credit check uses next-cycle occupancy so a held command never overcommits
    assign w_count_nxt  = r_count + c_CNTW'(w_push) - c_CNTW'(w_pop);
    assign w_out_nxt    = r_outstanding + c_CNTW'(w_cmd_fire) - c_CNTW'(w_push);
    assign w_credit_sum = {1'b0, w_count_nxt} + {1'b0, w_out_nxt};
    assign w_credit_ok  = (w_credit_sum < c_DEPTH);

    // Request acceptance, command issue and packet-level state machine
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_rd_ack   <= 1'b0;
            r_rd_busy  <= 1'b0;
            r_index    <= '0;
            r_word_num <= '0;
            r_nwords   <= '0;
            r_cmd_cnt  <= '0;
            r_cmd_val  <= 1'b0;
        end else begin
            r_rd_ack <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_rd_ack <= 1'b1;
                        if (w_legal) begin
                            r_index    <= rd_index;
                            r_word_num <= rd_word_num;
                            r_nwords   <= w_nwords;
                            r_cmd_cnt  <= '0;
                            // FIFO and credits are empty in IDLE, first command is safe
                            r_cmd_val  <= 1'b1;
                            r_rd_busy  <= 1'b1;
                            r_state    <= S_CMD;
                        end
                    end
                end
                S_CMD: begin
                    if (w_cmd_fire) begin
                        r_cmd_cnt <= r_cmd_cnt + 6'd1;
                        if ((r_cmd_cnt + 6'd1) == r_nwords) begin
                            r_cmd_val <= 1'b0;
                            r_state   <= S_DRAIN;
                        end else begin
                            r_cmd_val <= w_credit_ok;
                        end
                    end else if (!r_cmd_val) begin
                        r_cmd_val <= w_credit_ok;
                    end
                end
                S_DRAIN: begin
                    if (w_eof_hs) begin
                        r_rd_busy <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // FIFO pointers, occupancy and in-flight command credits
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_outstanding <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_AW'(1);
            end
            r_count       <= w_count_nxt;
            r_outstanding <= w_out_nxt;
        end
    end

    // FIFO storage, no reset needed since occupancy gates every read
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= ddr_rd_data;
        end
    end

    // Serialiser: pop a word, emit lanes MSB first, stop at the packet length
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_word     <= '0;
            r_lane     <= '0;
            r_have     <= 1'b0;
            r_out_cnt  <= '0;
            r_pkt_val  <= 1'b0;
            r_pkt_sof  <= 1'b0;
            r_pkt_eof  <= 1'b0;
            r_pkt_data <= '0;
        end else if (w_accept) begin
            r_out_cnt <= '0;
            r_have    <= 1'b0;
        end else if (w_adv) begin
            if (r_have) begin
                r_pkt_val  <= 1'b1;
                r_pkt_data <= r_word[127:112];
                r_pkt_sof  <= 1'b0;
                r_pkt_eof  <= w_last;
                r_word     <= {r_word[111:0], 16'h0000};
                r_out_cnt  <= r_out_cnt + 8'd1;
                r_lane     <= r_lane + 3'd1;
                r_have     <= (r_lane != 3'd7) && !w_last;
            end else if (w_pop) begin
                r_pkt_val  <= 1'b1;
                r_pkt_data <= w_head[127:112];
                r_pkt_sof  <= (r_out_cnt == 8'd0);
                r_pkt_eof  <= w_last;
                r_word     <= {w_head[111:0], 16'h0000};
                r_out_cnt  <= r_out_cnt + 8'd1;
                r_lane     <= 3'd1;
                r_have     <= !w_last;
            end else begin
                r_pkt_val  <= 1'b0;
                r_pkt_sof  <= 1'b0;
                r_pkt_eof  <= 1'b0;
                r_pkt_data <= '0;
            end
        end
    end

`ifdef BIT128TO16_CHK_EN
    logic r_rd_err;

    // Sticky flag for illegal lengths and unsolicited DDR data
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_err <= 1'b0;
        end else if ((w_accept && !w_legal) ||
                     (ddr_rd_data_val && (r_outstanding == '0))) begin
            r_rd_err <= 1'b1;
        end
    end

    assign rd_err = r_rd_err;
`else
    assign rd_err = 1'b0;
`endif

    assign rd_ack          = r_rd_ack;
    assign rd_busy         = r_rd_busy;
    assign ddr_rd_cmd_val  = r_cmd_val;
    assign ddr_rd_cmd_addr = {1'b0, r_cmd_cnt[4:0], r_index};
    assign ecm_pkt_index   = r_index;
    assign ecm_pkt_sof     = r_pkt_sof;
    assign ecm_pkt_eof     = r_pkt_eof;
    assign ecm_pkt_data    = r_pkt_data;
    assign ecm_pkt_val     = r_pkt_val;

endmodule
`default_nettype wire

// File: tb/tb_bit128to16.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_bit128to16
// Purpose  : Self-checking bench for bit128to16 with a DDR read-port model
//            and an output scoreboard. Honours BIT128TO16_CHK_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bit128to16;

    localparam int DEPTH = 4;
    localparam int LAT   = 3;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         rd_req = 1'b0;
    logic [9:0]   rd_index = '0;
    logic [7:0]   rd_word_num = '0;
    logic         rd_ack;
    logic         rd_busy;
    logic         ddr_rd_cmd_val;
    logic [15:0]  ddr_rd_cmd_addr;
    logic         ddr_rd_cmd_rdy = 1'b0;
    logic [127:0] ddr_rd_data = '0;
    logic         ddr_rd_data_val = 1'b0;
    logic [9:0]   ecm_pkt_index;
    logic         ecm_pkt_sof;
    logic         ecm_pkt_eof;
    logic [15:0]  ecm_pkt_data;
    logic         ecm_pkt_val;
    logic         ecm_pkt_rdy = 1'b0;
    logic         rd_err;

    always #5 clk = ~clk;

    bit128to16 #(.FIFO_DEPTH(DEPTH)) dut (
        .clk             (clk),
        .rst             (rst),
        .rd_req          (rd_req),
        .rd_index        (rd_index),
        .rd_word_num     (rd_word_num),
        .rd_ack          (rd_ack),
        .rd_busy         (rd_busy),
        .ddr_rd_cmd_val  (ddr_rd_cmd_val),
        .ddr_rd_cmd_addr (ddr_rd_cmd_addr),
        .ddr_rd_cmd_rdy  (ddr_rd_cmd_rdy),
        .ddr_rd_data     (ddr_rd_data),
        .ddr_rd_data_val (ddr_rd_data_val),
        .ecm_pkt_index   (ecm_pkt_index),
        .ecm_pkt_sof     (ecm_pkt_sof),
        .ecm_pkt_eof     (ecm_pkt_eof),
        .ecm_pkt_data    (ecm_pkt_data),
        .ecm_pkt_val     (ecm_pkt_val),
        .ecm_pkt_rdy     (ecm_pkt_rdy),
        .rd_err          (rd_err)
    );

    typedef struct { int due; logic [15:0] addr; } ret_t;
    typedef struct { logic [15:0] data; logic sof; logic eof; logic [9:0] idx; } exp_t;
    typedef struct { logic [9:0] idx; logic [7:0] num; int rmode; bit stall; int ncmd; } vec_t;

    ret_t ret_q[$];
    exp_t exp_q[$];
    vec_t vecs[8];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int rdy_mode = 0;
    bit stall_en = 1'b0;
    logic [9:0] cur_idx = '0;
    int cmd_k = 0, outs = 0, first_data = -1, first_val = -1, max_credit = 0, inj_cnt = 0;
    bit eof_seen = 1'b0;
    logic exp_err = 1'b0;

    logic        p_val = 0, p_rdy = 0, p_sof = 0, p_eof = 0, p_cval = 0, p_crdy = 0;
    logic [15:0] p_data = '0, p_caddr = '0;
    logic [9:0]  p_idx = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Payload of output word w of packet idx
    function automatic logic [15:0] g(input logic [9:0] idx, input int w);
        return {idx[7:0], w[7:0]} ^ 16'hC3A5;
    endfunction

    // DDR content at an address: eight consecutive packet words, MSB lane first
    function automatic logic [127:0] mk_word(input logic [15:0] a);
        logic [127:0] word;
        word = '0;
        for (int j = 0; j < 8; j++) begin
            word[127 - 16*j -: 16] = g(a[9:0], int'(a[14:10]) * 8 + j);
        end
        return word;
    endfunction

    function automatic logic [63:0] all_outs();
        return {15'd0, rd_ack, rd_busy, ddr_rd_cmd_val, ddr_rd_cmd_addr, ecm_pkt_index,
                ecm_pkt_sof, ecm_pkt_eof, ecm_pkt_data, ecm_pkt_val, rd_err};
    endfunction

    // One cycle: drive inputs at the falling edge, observe what the next rising edge will take
    task automatic tick();
        ret_t r;
        exp_t e;
        int   popped;
        @(negedge clk);
        cyc++;
        ecm_pkt_rdy    = (rdy_mode == 0) ? 1'b1 : (((cyc / 3) % 2) == 0);
        ddr_rd_cmd_rdy = stall_en ? ($urandom_range(0, 2) != 0) : 1'b1;
        ddr_rd_data_val = 1'b0;
        ddr_rd_data     = '0;
        if (inj_cnt > 0) begin
            ddr_rd_data_val = 1'b1;
            ddr_rd_data     = {8{16'hDEAD}};
            inj_cnt--;
        end else if (ret_q.size() > 0 && ret_q[0].due <= cyc) begin
            r = ret_q.pop_front();
            ddr_rd_data_val = 1'b1;
            ddr_rd_data     = mk_word(r.addr);
            if (first_data < 0) first_data = cyc;
        end
        if (!rst) begin
            if (p_val && !p_rdy)
                check("out_hold", {ecm_pkt_val, ecm_pkt_sof, ecm_pkt_eof, ecm_pkt_index, ecm_pkt_data},
                      {p_val, p_sof, p_eof, p_idx, p_data});
            if (p_cval && !p_crdy)
                check("cmd_hold", {ddr_rd_cmd_val, ddr_rd_cmd_addr}, {1'b1, p_caddr});
            if (eof_seen) begin
                check("busy_drop", rd_busy, 0);
                eof_seen = 1'b0;
            end
            if (ddr_rd_cmd_val && ddr_rd_cmd_rdy) begin
                check("cmd_addr", ddr_rd_cmd_addr, {1'b0, cmd_k[4:0], cur_idx});
                cmd_k++;
                ret_q.push_back('{cyc + LAT, ddr_rd_cmd_addr});
                popped = (outs + (ecm_pkt_val ? 1 : 0) + 7) / 8;
                if (cmd_k - popped > max_credit) max_credit = cmd_k - popped;
            end
            if (ecm_pkt_val && first_val < 0) first_val = cyc;
            if (ecm_pkt_val && ecm_pkt_rdy) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_out: got data 0x%0h, expected no output (cycle %0d)",
                             ecm_pkt_data, cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("out_word", {ecm_pkt_data, ecm_pkt_sof, ecm_pkt_eof, ecm_pkt_index},
                          {e.data, e.sof, e.eof, e.idx});
                end
                outs++;
                if (ecm_pkt_eof) begin
                    check("busy_at_eof", rd_busy, 1);
                    eof_seen = 1'b1;
                end
            end
        end
        p_val = ecm_pkt_val; p_rdy = ecm_pkt_rdy; p_sof = ecm_pkt_sof; p_eof = ecm_pkt_eof;
        p_data = ecm_pkt_data; p_idx = ecm_pkt_index;
        p_cval = ddr_rd_cmd_val; p_crdy = ddr_rd_cmd_rdy; p_caddr = ddr_rd_cmd_addr;
    endtask

    task automatic start_packet(input logic [9:0] idx, input logic [7:0] num,
                                input int rmode, input bit stall);
        int guard;
        rdy_mode = rmode; stall_en = stall; cur_idx = idx;
        cmd_k = 0; outs = 0; first_data = -1; first_val = -1; max_credit = 0;
        if (num != 0 && num <= 248)
            for (int w = 0; w < int'(num); w++)
                exp_q.push_back('{g(idx, w), (w == 0), (w == int'(num) - 1), idx});
        rd_index = idx; rd_word_num = num; rd_req = 1'b1;
        guard = 0;
        do begin
            tick();
            guard++;
        end while (!rd_ack && guard < 20);
        rd_req = 1'b0;
        check("rd_ack", rd_ack, 1);
    endtask

    task automatic run_packet(input logic [9:0] idx, input logic [7:0] num,
                              input int rmode, input bit stall, input int ncmd);
        int guard;
        bit legal;
        legal = (num != 0) && (num <= 248);
        start_packet(idx, num, rmode, stall);
`ifdef BIT128TO16_CHK_EN
        if (!legal) exp_err = 1'b1;
`endif
        guard = 0;
        while ((exp_q.size() != 0 || rd_busy || ret_q.size() != 0) && guard < 4000) begin
            tick();
            guard++;
        end
        if (guard >= 4000) begin
            n_tests++;
            n_fail++;
            $display("FAIL timeout: %0d words still expected for index 0x%0h", exp_q.size(), idx);
            exp_q.delete();
        end
        repeat (6) tick();
        check("cmd_count", cmd_k, ncmd);
        check("credit_le_depth", (max_credit <= DEPTH), 1);
        check("rd_err", rd_err, exp_err);
        if (legal) check("first_val_latency", first_val - first_data, 2);
    endtask

    initial begin
        int guard;
        vecs[0] = '{10'h155, 8'd94,  0, 1'b0, 12};
        vecs[1] = '{10'h2AA, 8'd1,   0, 1'b0, 1};
        vecs[2] = '{10'h3C1, 8'd248, 1, 1'b1, 31};
        vecs[3] = '{10'h011, 8'd0,   0, 1'b0, 0};
        vecs[4] = '{10'h022, 8'd249, 0, 1'b0, 0};
        vecs[5] = '{10'h100, 8'd8,   1, 1'b0, 1};
        vecs[6] = '{10'h0F0, 8'd9,   0, 1'b1, 2};
        vecs[7] = '{10'h3FF, 8'd247, 1, 1'b0, 31};

        rst = 1'b1;
        tick();
        tick();
        check("reset_outs", all_outs(), 0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 8; i++)
            run_packet(vecs[i].idx, vecs[i].num, vecs[i].rmode, vecs[i].stall, vecs[i].ncmd);

        // Abort a packet with reset after output word 20
        start_packet(10'h155, 8'd94, 0, 1'b0);
        guard = 0;
        while (outs < 20 && guard < 500) begin
            tick();
            guard++;
        end
        check("reached_word20", outs, 20);
        #2 rst = 1'b1;
        #1 check("async_reset_outs", all_outs(), 0);
        exp_q.delete();
        ret_q.delete();
        eof_seen = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        exp_err = 1'b0;
        tick();
        check("err_after_reset", rd_err, 0);
        inj_cnt = 2;
        repeat (6) tick();
`ifdef BIT128TO16_CHK_EN
        exp_err = 1'b1;
`endif
        check("unsolicited_err", rd_err, exp_err);
        check("idle_after_unsolicited", {ddr_rd_cmd_val, ecm_pkt_val, rd_busy}, 0);
        run_packet(10'h0AB, 8'd20, 0, 1'b0, 3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
